// File: rtl/video_pkg.sv
// Shared types for the video pattern generator: runtime timing mode,
// pattern selector encoding and the colour-bar palette.
package video_pkg;

  // Field width of every timing value carried in VideoMode.
  localparam int VM_CNT_W = 12;

  typedef struct packed {
    logic [VM_CNT_W-1:0] h_sync;
    logic [VM_CNT_W-1:0] h_back_porch;
    logic [VM_CNT_W-1:0] h_active;
    logic [VM_CNT_W-1:0] h_front_porch;
    logic [VM_CNT_W-1:0] h_total;
    logic                h_sync_pol;
    logic [VM_CNT_W-1:0] v_sync;
    logic [VM_CNT_W-1:0] v_back_porch;
    logic [VM_CNT_W-1:0] v_active;
    logic [VM_CNT_W-1:0] v_front_porch;
    logic [VM_CNT_W-1:0] v_total;
    logic                v_sync_pol;
  } VideoMode;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_FLASH = 2'd2,
    PAT_RAMP  = 2'd3
  } pattern_e;

  // Bar palette as {r,g,b} on/off bits: red, green, blue, white,
  // black, cyan, yellow, magenta.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 3'b100;
      3'd1:    bar_rgb = 3'b010;
      3'd2:    bar_rgb = 3'b001;
      3'd3:    bar_rgb = 3'b111;
      3'd4:    bar_rgb = 3'b000;
      3'd5:    bar_rgb = 3'b011;
      3'd6:    bar_rgb = 3'b110;
      default: bar_rgb = 3'b101;
    endcase
  endfunction

endpackage

// File: rtl/delayline.sv
// Fixed-length register pipeline with asynchronous active-low clear.
// CYCLES=0 degenerates to a wire.
module delayline #(
  parameter int CYCLES = 1,
  parameter int WIDTH  = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (CYCLES == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = clock ^ reset_n;
    assign dout        = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [CYCLES];

    // Shift the data word one stage per clock; clear every stage on reset.
    // NOTE: this array is a chain of flops, not a RAM, so resetting every
    // entry is cheap and keeps the outputs at 0 while reset is held.
    // NOTE: non-blocking assignments make each stage take the previous
    // stage's old value, which is what gives one clock of delay per stage.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < CYCLES; i++) stage[i] <= '0;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < CYCLES; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[CYCLES-1];
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator. Produces HSYNC/VSYNC/DE from a
// runtime VideoMode and renders black, colour bars, a frame-periodic flash
// or a horizontal ramp. Outputs appear PIPE_DELAY+1 clocks after the
// counter state that produced them, all mutually aligned.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int CNT_W       = VM_CNT_W,
  parameter int COLOR_W     = 8,
  parameter int NUM_BARS    = 8,
  parameter int PIPE_DELAY  = 2,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  VideoMode               videoMode,
  input  logic [1:0]             pattern_sel,
  input  logic [FRAME_CNT_W-1:0] flash_period,
  input  logic [FRAME_CNT_W-1:0] flash_on,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   de,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start,
  output logic                   flash_active
);

  localparam int BAR_SHIFT = $clog2(NUM_BARS);
  localparam int OUT_W     = 3*COLOR_W + 5;

  // Shadow configuration, stable for a whole frame.
  VideoMode               mode_q;
  pattern_e               pat_q;
  logic [FRAME_CNT_W-1:0] period_q;
  logic [FRAME_CNT_W-1:0] on_q;
  logic                   cfg_load_en;

  // Raster and frame counters.
  logic [CNT_W-1:0]       x_cnt;
  logic [CNT_W-1:0]       y_cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  // Timing fields at counter width and derived wrap points.
  logic [CNT_W-1:0] hs, hbp, ha, ht, vs, vbp, va, vt;
  logic [CNT_W-1:0] h_last, v_last;
  logic             x_wrap, y_wrap, frame_end;

  // Active-window bounds, wide enough that the sums never overflow.
  logic [CNT_W+1:0] h_start, h_end, v_start, v_end;
  logic             h_act, v_act;

  // Per-pixel generation results.
  logic [CNT_W-1:0]   xpos;
  logic [CNT_W-1:0]   bar_w;
  logic [2:0]         bar_idx;
  logic [2:0]         bar_bits;
  logic               flash_white;
  logic               de_c, hsync_c, vsync_c, fs_c, fa_c;
  logic [COLOR_W-1:0] red_c, green_c, blue_c;

  logic [OUT_W-1:0] gen_q;
  logic [OUT_W-1:0] pipe_out;

  // Front porches are implied by the totals and never compared directly.
  logic unused_porches;
  assign unused_porches = ^{mode_q.h_front_porch, mode_q.v_front_porch};

  // Config load strobe: held high through reset and the first clock after.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cfg_load_en <= 1'b1;
    else          cfg_load_en <= 1'b0;
  end

  // Shadow config: reloads during reset and at each frame boundary only.
  // Deliberately no async reset, so these load from the live inputs
  // instead of from constants.
  always_ff @(posedge clock) begin
    if (cfg_load_en || frame_end) begin
      mode_q   <= videoMode;
      pat_q    <= pattern_e'(pattern_sel);
      period_q <= flash_period;
      on_q     <= flash_on;
    end
  end

  // Resize timing fields and derive counter wrap points; h_total=0 acts as 1.
  // NOTE: every variable gets a value before any branch, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    hs  = CNT_W'(mode_q.h_sync);
    hbp = CNT_W'(mode_q.h_back_porch);
    ha  = CNT_W'(mode_q.h_active);
    ht  = CNT_W'(mode_q.h_total);
    vs  = CNT_W'(mode_q.v_sync);
    vbp = CNT_W'(mode_q.v_back_porch);
    va  = CNT_W'(mode_q.v_active);
    vt  = CNT_W'(mode_q.v_total);

    h_last = (ht == '0) ? '0 : ht - CNT_W'(1);
    v_last = (vt == '0) ? '0 : vt - CNT_W'(1);

    x_wrap    = (x_cnt >= h_last);
    y_wrap    = (y_cnt >= v_last);
    frame_end = x_wrap && y_wrap;
  end

  // Raster counters: X every clock, Y on X wrap, both restart at the frame end.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (x_wrap) begin
      x_cnt <= '0;
      y_cnt <= y_wrap ? '0 : y_cnt + CNT_W'(1);
    end else begin
      x_cnt <= x_cnt + CNT_W'(1);
    end
  end

  // Flash frame counter: runs in every pattern, period 0 or 1 pins it at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      if (period_q <= FRAME_CNT_W'(1))                  frame_cnt <= '0;
      else if (frame_cnt >= period_q - FRAME_CNT_W'(1)) frame_cnt <= '0;
      else                                              frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

  // Sync levels, active window and active-area X coordinate.
  always_comb begin
    h_start = (CNT_W+2)'(hs) + (CNT_W+2)'(hbp);
    h_end   = h_start + (CNT_W+2)'(ha);
    v_start = (CNT_W+2)'(vs) + (CNT_W+2)'(vbp);
    v_end   = v_start + (CNT_W+2)'(va);

    h_act = ((CNT_W+2)'(x_cnt) >= h_start) && ((CNT_W+2)'(x_cnt) < h_end);
    v_act = ((CNT_W+2)'(y_cnt) >= v_start) && ((CNT_W+2)'(y_cnt) < v_end);
    de_c  = h_act && v_act;

    hsync_c = (x_cnt < hs) ? mode_q.h_sync_pol : ~mode_q.h_sync_pol;
    vsync_c = (y_cnt < vs) ? mode_q.v_sync_pol : ~mode_q.v_sync_pol;
    fs_c    = (x_cnt == '0) && (y_cnt == '0);

    xpos = x_cnt - h_start[CNT_W-1:0];
  end

  // Bar index by threshold compare instead of a divider; when h_active is
  // not a multiple of NUM_BARS the last bar absorbs the leftover pixels.
  always_comb begin
    bar_w   = ha >> BAR_SHIFT;
    bar_idx = '0;
    for (int k = 1; k < NUM_BARS; k++) begin
      if ((CNT_W+3)'(xpos) >= (CNT_W+3)'(k) * (CNT_W+3)'(bar_w)) bar_idx = 3'(k);
    end
    bar_bits = bar_rgb(bar_idx);
  end

  // Pixel colour per pattern; black outside the active window.
  always_comb begin
    flash_white = (frame_cnt < on_q);
    fa_c        = (pat_q == PAT_FLASH) && flash_white && de_c;
    red_c       = '0;
    green_c     = '0;
    blue_c      = '0;
    if (de_c) begin
      case (pat_q)
        PAT_BARS: begin
          red_c   = {COLOR_W{bar_bits[2]}};
          green_c = {COLOR_W{bar_bits[1]}};
          blue_c  = {COLOR_W{bar_bits[0]}};
        end
        PAT_FLASH: begin
          red_c   = {COLOR_W{flash_white}};
          green_c = {COLOR_W{flash_white}};
          blue_c  = {COLOR_W{flash_white}};
        end
        PAT_RAMP: begin
          red_c   = COLOR_W'(xpos);
          green_c = COLOR_W'(xpos);
          blue_c  = COLOR_W'(xpos);
        end
        default: ;
      endcase
    end
  end

  // Generation register: first of the PIPE_DELAY+1 output stages.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) gen_q <= '0;
    else          gen_q <= {red_c, green_c, blue_c, de_c, hsync_c, vsync_c, fs_c, fa_c};
  end

  delayline #(
    .CYCLES (PIPE_DELAY),
    .WIDTH  (OUT_W)
  ) u_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (gen_q),
    .dout    (pipe_out)
  );

  assign {red, green, blue, de, hsync, vsync, frame_start, flash_active} = pipe_out;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: table of {coordinate, expected
// outputs} vectors per configuration plus hand-written sequences for
// frame statistics, mid-frame config changes and asynchronous reset.
module tb_video_pattern_gen;
  import video_pkg::*;

  localparam int HT    = 28;
  localparam int VT    = 10;
  localparam int FRAME = HT * VT;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  VideoMode   mode;
  logic [1:0] pattern_sel;
  logic [7:0] flash_period;
  logic [7:0] flash_on;

  logic [7:0] red, green, blue;
  logic       de, hsync, vsync, frame_start, flash_active;
  logic [9:0] red10, green10, blue10;
  logic       de10, hsync10, vsync10, frame_start10, flash_active10;

  int checks = 0;
  int errors = 0;
  int pix    = 0;   // raster index of the pixel currently on the outputs

  typedef struct {
    int          scen;
    int          f;
    int          x;
    int          y;
    logic [23:0] rgb;
    logic [4:0]  ctl;   // {de, hsync, vsync, frame_start, flash_active}
  } vec_t;

  vec_t vecs[$];

  video_pattern_gen #(
    .CNT_W(12), .COLOR_W(8), .NUM_BARS(8), .PIPE_DELAY(2), .FRAME_CNT_W(8)
  ) dut (
    .clock(clk), .reset_n(rst_n), .videoMode(mode), .pattern_sel(pattern_sel),
    .flash_period(flash_period), .flash_on(flash_on),
    .red(red), .green(green), .blue(blue), .de(de), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .flash_active(flash_active)
  );

  video_pattern_gen #(
    .CNT_W(12), .COLOR_W(10), .NUM_BARS(8), .PIPE_DELAY(2), .FRAME_CNT_W(8)
  ) dut10 (
    .clock(clk), .reset_n(rst_n), .videoMode(mode), .pattern_sel(pattern_sel),
    .flash_period(flash_period), .flash_on(flash_on),
    .red(red10), .green(green10), .blue(blue10), .de(de10), .hsync(hsync10),
    .vsync(vsync10), .frame_start(frame_start10), .flash_active(flash_active10)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [28:0] obs();
    return {red, green, blue, de, hsync, vsync, frame_start, flash_active};
  endfunction

  function automatic logic [34:0] obs10();
    return {red10, green10, blue10, de10, hsync10, vsync10, frame_start10, flash_active10};
  endfunction

  function automatic logic [34:0] exp10(input logic [23:0] rgb, input logic [4:0] ctl);
    return {rgb[23] ? 10'h3FF : 10'h000,
            rgb[15] ? 10'h3FF : 10'h000,
            rgb[7]  ? 10'h3FF : 10'h000, ctl};
  endfunction

  function automatic VideoMode mk_mode(input int ha);
    VideoMode m;
    m.h_sync        = 12'd4;
    m.h_back_porch  = 12'd4;
    m.h_active      = 12'(ha);
    m.h_front_porch = 12'd4;
    m.h_total       = 12'd28;
    m.h_sync_pol    = 1'b1;
    m.v_sync        = 12'd2;
    m.v_back_porch  = 12'd2;
    m.v_active      = 12'd4;
    m.v_front_porch = 12'd2;
    m.v_total       = 12'd10;
    m.v_sync_pol    = 1'b0;
    return m;
  endfunction

  task automatic add(input int s, input int f, input int x, input int y,
                     input logic [23:0] rgb, input logic [4:0] ctl);
    vecs.push_back('{s, f, x, y, rgb, ctl});
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    pix++;
  endtask

  task automatic goto(input int f, input int x, input int y);
    int target;
    target = f*FRAME + y*HT + x;
    if (target < pix) check("goto order", pix, target);
    while (pix < target) tick();
  endtask

  // Reset with a fresh configuration, then check the 3-clock release latency.
  task automatic do_reset(input int pat, input int period, input int on, input int ha);
    pattern_sel  = 2'(pat);
    flash_period = 8'(period);
    flash_on     = 8'(on);
    mode         = mk_mode(ha);
    rst_n        = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("in reset outputs", obs(), 0);
    check("in reset outputs c10", obs10(), 0);
    rst_n = 1'b1;
    pix   = -3;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k < 3) check($sformatf("release clk%0d zero", k), obs(), 0);
    end
    check("release clk3 first pixel", obs(), {24'h0, 5'b01010});
  endtask

  task automatic apply_scen(input int s);
    foreach (vecs[i]) begin
      if (vecs[i].scen == s) begin
        goto(vecs[i].f, vecs[i].x, vecs[i].y);
        check($sformatf("s%0d f%0d x%0d y%0d", s, vecs[i].f, vecs[i].x, vecs[i].y),
              obs(), {vecs[i].rgb, vecs[i].ctl});
        check($sformatf("c10 s%0d f%0d x%0d y%0d", s, vecs[i].f, vecs[i].x, vecs[i].y),
              obs10(), exp10(vecs[i].rgb, vecs[i].ctl));
      end
    end
  endtask

  // Whole-frame statistics: sync duty, hsync period and DE count.
  task automatic measure_frame(input int f, input int exp_de);
    int   hs_cnt, vs_low, de_cnt, rises, bad, last;
    logic prev;
    hs_cnt = 0; vs_low = 0; de_cnt = 0; rises = 0; bad = 0; last = -1; prev = 1'b0;
    goto(f, 0, 0);
    for (int i = 0; i < FRAME; i++) begin
      if (hsync && !prev) begin
        rises++;
        if (last >= 0 && (i - last) != HT) bad++;
        last = i;
      end
      prev = hsync;
      if (hsync)  hs_cnt++;
      if (!vsync) vs_low++;
      if (de)     de_cnt++;
      tick();
    end
    check($sformatf("f%0d hsync high count", f), hs_cnt, 4*VT);
    check($sformatf("f%0d hsync rises", f), rises, VT);
    check($sformatf("f%0d hsync period errors", f), bad, 0);
    check($sformatf("f%0d vsync low count", f), vs_low, 2*HT);
    check($sformatf("f%0d de count", f), de_cnt, exp_de);
  endtask

  initial begin
    logic [7:0]  v8;
    logic [23:0] rgb_e;
    logic        de_e;

    // Scenario 0: black, timing only.
    add(0, 0,  0, 0, 24'h000000, 5'b01010);
    add(0, 0,  1, 0, 24'h000000, 5'b01000);
    add(0, 0,  3, 0, 24'h000000, 5'b01000);
    add(0, 0,  4, 0, 24'h000000, 5'b00000);
    add(0, 0, 27, 1, 24'h000000, 5'b00000);
    add(0, 0,  0, 2, 24'h000000, 5'b01100);
    add(0, 0,  7, 4, 24'h000000, 5'b00100);
    add(0, 0,  8, 4, 24'h000000, 5'b10100);
    add(0, 0, 23, 7, 24'h000000, 5'b10100);
    add(0, 0, 24, 7, 24'h000000, 5'b00100);
    add(0, 0,  8, 8, 24'h000000, 5'b00100);
    add(0, 0, 27, 9, 24'h000000, 5'b00100);
    add(0, 1,  0, 0, 24'h000000, 5'b01010);
    // Scenario 1: colour bars, bar_w = 2.
    add(1, 0,  8, 4, 24'hFF0000, 5'b10100);
    add(1, 0,  9, 4, 24'hFF0000, 5'b10100);
    add(1, 0, 10, 4, 24'h00FF00, 5'b10100);
    add(1, 0, 12, 4, 24'h0000FF, 5'b10100);
    add(1, 0, 16, 4, 24'h000000, 5'b10100);
    add(1, 0, 18, 4, 24'h00FFFF, 5'b10100);
    add(1, 0, 20, 4, 24'hFFFF00, 5'b10100);
    add(1, 0, 24, 4, 24'h000000, 5'b00100);
    add(1, 0, 14, 5, 24'hFFFFFF, 5'b10100);
    add(1, 0, 15, 5, 24'hFFFFFF, 5'b10100);
    add(1, 0, 22, 6, 24'hFF00FF, 5'b10100);
    add(1, 0, 23, 7, 24'hFF00FF, 5'b10100);
    // Scenario 2: flash, period 4, one white frame.
    add(2, 0,  0, 0, 24'h000000, 5'b01010);
    add(2, 0,  5, 4, 24'h000000, 5'b00100);
    add(2, 0,  8, 4, 24'hFFFFFF, 5'b10101);
    add(2, 0, 23, 7, 24'hFFFFFF, 5'b10101);
    add(2, 1,  8, 4, 24'h000000, 5'b10100);
    add(2, 2, 10, 5, 24'h000000, 5'b10100);
    add(2, 3,  8, 4, 24'h000000, 5'b10100);
    add(2, 4,  5, 4, 24'h000000, 5'b00100);
    add(2, 4,  8, 4, 24'hFFFFFF, 5'b10101);
    add(2, 7, 20, 6, 24'h000000, 5'b10100);
    add(2, 8,  0, 0, 24'h000000, 5'b01010);
    add(2, 8, 20, 6, 24'hFFFFFF, 5'b10101);
    // Scenario 3: flash, period 0 means constant white.
    add(3, 0,  8, 4, 24'hFFFFFF, 5'b10101);
    add(3, 1,  9, 5, 24'hFFFFFF, 5'b10101);
    add(3, 3, 10, 6, 24'hFFFFFF, 5'b10101);
    // Scenario 4: ramp with h_active = 0, never active.
    add(4, 0,  8, 4, 24'h000000, 5'b00100);
    add(4, 0, 15, 6, 24'h000000, 5'b00100);

    pattern_sel  = 2'd0;
    flash_period = 8'd0;
    flash_on     = 8'd0;
    mode         = mk_mode(16);

    do_reset(0, 0, 0, 16);
    apply_scen(0);
    measure_frame(1, 64);

    do_reset(1, 0, 0, 16);
    apply_scen(1);

    do_reset(2, 4, 1, 16);
    apply_scen(2);

    do_reset(2, 0, 1, 16);
    apply_scen(3);

    do_reset(3, 0, 0, 0);
    apply_scen(4);
    measure_frame(1, 0);

    // Mid-frame switch to ramp with 8 active pixels: current frame keeps bars.
    do_reset(1, 0, 0, 16);
    goto(0, 0, 5);
    pattern_sel = 2'd3;
    mode        = mk_mode(8);
    goto(0, 22, 6);
    check("midframe old bars magenta", obs(), {24'hFF00FF, 5'b10100});
    goto(0, 8, 7);
    check("midframe old bars red", obs(), {24'hFF0000, 5'b10100});
    for (int x = 7; x <= 16; x++) begin
      goto(1, x, 5);
      de_e  = (x >= 8) && (x < 16);
      v8    = 8'(x - 8);
      rgb_e = de_e ? {v8, v8, v8} : 24'h0;
      check($sformatf("ramp f1 x%0d y5", x), obs(), {rgb_e, de_e, 4'b0100});
    end

    // Asynchronous reset between clock edges clears the outputs at once.
    goto(1, 12, 6);
    check("ramp before async reset", obs(), {24'h040404, 5'b10100});
    #1 rst_n = 1'b0;
    #1;
    check("async reset outputs", obs(), 0);
    check("async reset outputs c10", obs10(), 0);

    do_reset(0, 0, 0, 16);
    apply_scen(0);
    measure_frame(1, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
